env_alarm_ctrl: RTL and testbench

//  Threshold alarm stage downstream of the per-channel averaging filters.

---
 rtl/env_alarm_ctrl_pkg.sv | 25 ++
 rtl/env_alarm_ctrl_beep_tone_gen.sv | 57 +++++
 rtl/env_alarm_ctrl.sv | 147 ++++++++++++++
 tb/tb_env_alarm_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/env_alarm_ctrl_pkg.sv
// Shared definitions for the environment alarm stage: state encodings and default limits.
// The display stage reuses the same encodings and limits.
package env_alarm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL  = 3'd0,
        ST_ARMING  = 3'd1,
        ST_ALARM   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_HOLD    = 3'd4
    } alarm_state_t;

    localparam int unsigned DEF_TEMP_HI     = 300;
    localparam int unsigned DEF_TEMP_HYST   = 10;
    localparam int unsigned DEF_HUMI_HI     = 800;
    localparam int unsigned DEF_HUMI_HYST   = 20;
    localparam int unsigned DEF_CONFIRM_N   = 3;
    localparam int unsigned DEF_BEEP_HALF   = 12_500;
    localparam int unsigned DEF_PATTERN_CYC = 12_500_000;

    function automatic logic in_alarm(input alarm_state_t s);
        return (s == ST_ALARM) || (s == ST_RELEASE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/env_alarm_ctrl_beep_tone_gen.sv
// Buzzer tone/gate generator: a tone phase gated by a slower on/off pattern, idle while disabled.
module beep_tone_gen
    import env_alarm_ctrl_pkg::*;
#(
    parameter int unsigned BEEP_HALF   = DEF_BEEP_HALF,
    parameter int unsigned PATTERN_CYC = DEF_PATTERN_CYC
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic beep
);

    localparam int unsigned TW = $clog2(BEEP_HALF + 1);
    localparam int unsigned GW = $clog2(PATTERN_CYC + 1);
    localparam logic [TW-1:0] TONE_LOAD = TW'(BEEP_HALF);
    localparam logic [GW-1:0] GATE_LOAD = GW'(PATTERN_CYC);

    logic [TW-1:0] tone_cnt, tone_left;
    logic [GW-1:0] gate_cnt, gate_left;
    logic          tone_ph, gate_ph;

    // Down-counters park at zero while idle; zero reads as a full half-period on the first enabled cycle.
    assign tone_left = (tone_cnt == '0) ? TONE_LOAD : tone_cnt;
    assign gate_left = (gate_cnt == '0) ? GATE_LOAD : gate_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tone_cnt <= '0;
            gate_cnt <= '0;
            tone_ph  <= 1'b1;
            gate_ph  <= 1'b1;
            beep     <= 1'b0;
        end else if (!en) begin
            tone_cnt <= '0;
            gate_cnt <= '0;
            tone_ph  <= 1'b1;
            gate_ph  <= 1'b1;
            beep     <= 1'b0;
        end else begin
            beep <= tone_ph & gate_ph;
            if (tone_left == TW'(1)) begin
                tone_cnt <= TONE_LOAD;
                tone_ph  <= ~tone_ph;
            end else begin
                tone_cnt <= tone_left - TW'(1);
            end
            if (gate_left == GW'(1)) begin
                gate_cnt <= GATE_LOAD;
                gate_ph  <= ~gate_ph;
            end else begin
                gate_cnt <= gate_left - GW'(1);
            end
        end
    end

endmodule

// File: rtl/env_alarm_ctrl.sv
// Sample-synchronous threshold alarm with hysteresis and N-sample confirmation, driving the buzzer.
// Define ALARM_LATCH_EN to hold the alarm after release until acknowledged via ack_flag.
//
//  state   | meaning
//  NORMAL  | no alarm, waiting for an over-limit sample
//  ARMING  | counting consecutive over-limit samples
//  ALARM   | alarm active, waiting for a clear sample
//  RELEASE | alarm active, counting consecutive clear samples
//  HOLD    | alarm latched after release, waiting for ack_flag (ALARM_LATCH_EN only)
module env_alarm_ctrl
    import env_alarm_ctrl_pkg::*;
#(
    parameter int unsigned TEMP_HI     = DEF_TEMP_HI,
    parameter int unsigned TEMP_HYST   = DEF_TEMP_HYST,
    parameter int unsigned HUMI_HI     = DEF_HUMI_HI,
    parameter int unsigned HUMI_HYST   = DEF_HUMI_HYST,
    parameter int unsigned CONFIRM_N   = DEF_CONFIRM_N,
    parameter int unsigned BEEP_HALF   = DEF_BEEP_HALF,
    parameter int unsigned PATTERN_CYC = DEF_PATTERN_CYC
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [11:0] temp_in,
    input  logic [11:0] humi_in,
    input  logic        data_valid,
    input  logic        ack_flag,
    output logic        alarm,
    output logic [1:0]  alarm_src,
    output logic        beep
);

    localparam logic [11:0] TEMP_SET = 12'(TEMP_HI);
    localparam logic [11:0] TEMP_CLR = 12'(TEMP_HI - TEMP_HYST);
    localparam logic [11:0] HUMI_SET = 12'(HUMI_HI);
    localparam logic [11:0] HUMI_CLR = 12'(HUMI_HI - HUMI_HYST);
    localparam logic [3:0]  CONF     = 4'(CONFIRM_N);
`ifdef ALARM_LATCH_EN
    localparam alarm_state_t REL_DONE = ST_HOLD;
`else
    localparam alarm_state_t REL_DONE = ST_NORMAL;
    logic unused_ack;
    assign unused_ack = ack_flag;
`endif

    alarm_state_t state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [1:0]   over_ch;
    logic         over, clear;

    assign over_ch = {humi_in >= HUMI_SET, temp_in >= TEMP_SET};
    assign over    = |over_ch;
    assign clear   = (temp_in < TEMP_CLR) && (humi_in < HUMI_CLR);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_NORMAL: if (data_valid && over) begin
                if (CONF == 4'd1) begin
                    state_nxt = ST_ALARM;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_ARMING;
                    cnt_nxt   = 4'd1;
                end
            end
            ST_ARMING: if (data_valid) begin
                if (!over) begin
                    state_nxt = ST_NORMAL;
                    cnt_nxt   = '0;
                end else if (cnt + 4'd1 == CONF) begin
                    state_nxt = ST_ALARM;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ST_ALARM: if (data_valid && clear) begin
                if (CONF == 4'd1) begin
                    state_nxt = REL_DONE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = 4'd1;
                end
            end
            ST_RELEASE: if (data_valid) begin
                if (!clear) begin
                    state_nxt = ST_ALARM;
                    cnt_nxt   = '0;
                end else if (cnt + 4'd1 == CONF) begin
                    state_nxt = REL_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
`ifdef ALARM_LATCH_EN
            ST_HOLD: if (ack_flag) begin
                state_nxt = ST_NORMAL;
                cnt_nxt   = '0;
            end
`endif
            default: begin
                state_nxt = ST_NORMAL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // alarm mirrors the registered state; alarm_src is loaded on entry and only grows while active.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            alarm     <= 1'b0;
            alarm_src <= 2'b00;
        end else begin
            alarm <= in_alarm(state_nxt);
            if (!in_alarm(state_nxt))
                alarm_src <= 2'b00;
            else if (!alarm)
                alarm_src <= over_ch;
            else if (data_valid && state != ST_HOLD)
                alarm_src <= alarm_src | over_ch;
        end
    end

    beep_tone_gen #(
        .BEEP_HALF   (BEEP_HALF),
        .PATTERN_CYC (PATTERN_CYC)
    ) u_beep (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (alarm),
        .beep      (beep)
    );

endmodule

// File: tb/tb_env_alarm_ctrl.sv
// Scoreboard bench for env_alarm_ctrl: stimulus queues expected output transitions, a monitor checks them.
module tb_env_alarm_ctrl;

    localparam int unsigned BH   = 4;
    localparam int unsigned PC   = 32;
    localparam int unsigned GAP  = 2;
`ifdef ALARM_LATCH_EN
    localparam int unsigned HOLD_EXTRA = GAP + 4;
`else
    localparam int unsigned HOLD_EXTRA = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [11:0] temp_in;
    logic [11:0] humi_in;
    logic        data_valid;
    logic        ack_flag;
    logic        alarm;
    logic [1:0]  alarm_src;
    logic        beep;

    env_alarm_ctrl #(
        .TEMP_HI(300), .TEMP_HYST(10), .HUMI_HI(800), .HUMI_HYST(20),
        .CONFIRM_N(3), .BEEP_HALF(BH), .PATTERN_CYC(PC)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .temp_in(temp_in), .humi_in(humi_in),
        .data_valid(data_valid), .ack_flag(ack_flag), .alarm(alarm), .alarm_src(alarm_src),
        .beep(beep)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  val;
        int unsigned cyc;
    } ev_t;

    ev_t q_alarm[$];
    ev_t q_src[$];
    ev_t q_beep[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic void push_beep(input int unsigned r, input int unsigned fall_at);
        logic        prev;
        logic        b;
        int unsigned j;
        prev = 1'b0;
        for (int unsigned k = r + 1; k < fall_at; k++) begin
            j = k - 1 - r;
            b = ((j / BH) % 2 == 0) && ((j / PC) % 2 == 0);
            if (b != prev) begin
                q_beep.push_back('{val: {1'b0, b}, cyc: k});
                prev = b;
            end
        end
        if (prev) q_beep.push_back('{val: 2'b00, cyc: fall_at});
    endfunction

    task automatic take(input int which, input string nm, input logic [1:0] act);
        ev_t e;
        int  sz;
        case (which)
            0:       sz = q_alarm.size();
            1:       sz = q_src.size();
            default: sz = q_beep.size();
        endcase
        checks++;
        if (sz == 0) begin
            errors++;
            $display("FAIL %s: unexpected change to %0d at cycle %0d", nm, act, cyc);
            return;
        end
        case (which)
            0:       e = q_alarm.pop_front();
            1:       e = q_src.pop_front();
            default: e = q_beep.pop_front();
        endcase
        if (e.val !== act || e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: got %0d at cycle %0d, expected %0d at cycle %0d",
                     nm, act, cyc, e.val, e.cyc);
        end
    endtask

    logic       prev_alarm = 1'b0;
    logic [1:0] prev_src   = 2'b00;
    logic       prev_beep  = 1'b0;

    always @(negedge sys_clk) begin
        if (alarm !== prev_alarm)   take(0, "alarm", {1'b0, alarm});
        if (alarm_src !== prev_src) take(1, "alarm_src", alarm_src);
        if (beep !== prev_beep)     take(2, "beep", {1'b0, beep});
        prev_alarm = alarm;
        prev_src   = alarm_src;
        prev_beep  = beep;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic sample(input int t, input int h);
        repeat (GAP - 1) @(posedge sys_clk);
        #1;
        temp_in    = 12'(t);
        humi_in    = 12'(h);
        data_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        ack_flag = 1'b1;
        @(posedge sys_clk);
        #1;
        ack_flag = 1'b0;
    endtask

    int unsigned r, f;

    initial begin
        sys_rst_n  = 1'b1;
        temp_in    = '0;
        humi_in    = '0;
        data_valid = 1'b0;
        ack_flag   = 1'b0;
        #1 sys_rst_n = 1'b0;
        idle(3);
        chk("reset_alarm", {1'b0, alarm}, 2'b00);
        chk("reset_src", alarm_src, 2'b00);
        chk("reset_beep", {1'b0, beep}, 2'b00);
        sys_rst_n = 1'b1;
        idle(2);

        // Temperature alarm, ack ignored while active, then release by clear samples.
        r = cyc + 3 * GAP;
        f = r + 70 + 3 * GAP + HOLD_EXTRA;
        q_alarm.push_back('{val: 2'b01, cyc: r});
        q_alarm.push_back('{val: 2'b00, cyc: f});
        q_src.push_back('{val: 2'b01, cyc: r});
        q_src.push_back('{val: 2'b00, cyc: f});
        push_beep(r, f + 1);
        repeat (3) sample(305, 500);
        idle(30);
        ack_pulse();
        idle(39);
        repeat (3) sample(289, 500);
`ifdef ALARM_LATCH_EN
        sample(305, 810);
        idle(3);
        ack_pulse();
`endif
        idle(6);

        // Band sample restarts confirmation: no alarm.
        sample(305, 500);
        sample(305, 500);
        sample(295, 500);
        sample(305, 500);
        sample(305, 500);
        sample(200, 500);
        ack_pulse();
        idle(4);

        // Band sample during release returns to ALARM; humidity widens the source; reset mid-tone.
        r = cyc + 3 * GAP;
        f = r + 6 * GAP + 5;
        q_alarm.push_back('{val: 2'b01, cyc: r});
        q_alarm.push_back('{val: 2'b00, cyc: f});
        q_src.push_back('{val: 2'b01, cyc: r});
        q_src.push_back('{val: 2'b11, cyc: r + 5 * GAP});
        q_src.push_back('{val: 2'b00, cyc: f});
        push_beep(r, f);
        repeat (3) sample(305, 500);
        sample(289, 500);
        sample(289, 500);
        sample(295, 500);
        sample(289, 500);
        sample(289, 810);
        sample(310, 500);
        idle(5);
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_alarm", {1'b0, alarm}, 2'b00);
        chk("async_rst_beep", {1'b0, beep}, 2'b00);
        idle(2);
        sys_rst_n = 1'b1;
        idle(10);

        chk("alarm_queue_left", 2'(q_alarm.size() > 3 ? 3 : q_alarm.size()), 2'b00);
        chk("src_queue_left", 2'(q_src.size() > 3 ? 3 : q_src.size()), 2'b00);
        chk("beep_queue_left", 2'(q_beep.size() > 3 ? 3 : q_beep.size()), 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
